// File: rtl/div24u12_seq.sv
// div24u12_seq: sequential restoring 2W/W unsigned divider, one quotient bit per cycle, valid/ready on both sides
// DIV_ROUND_EN: round the normal-case quotient to nearest, saturating at all-ones
module div24u12_seq #(
  parameter int WIDTH = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   Q,
  output logic [WIDTH-1:0]   R,
  output logic               ovf,
  output logic               dbz
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] p, lo, b_r, p_nx, q_nx, q_fin;
  logic [WIDTH-2:0] qt;
  logic [WIDTH:0]   t;
  logic [CW-1:0]    cnt;
  logic             exc_dbz, exc_ovf, ge, accept;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign accept    = in_valid & in_ready;
  assign t         = {p, lo[WIDTH-1]};
  assign ge        = t >= {1'b0, b_r};
  assign p_nx      = ge ? WIDTH'(t - {1'b0, b_r}) : t[WIDTH-1:0];
  assign q_nx      = {qt, ge};
`ifdef DIV_ROUND_EN
  assign q_fin = ({p_nx, 1'b0} >= {1'b0, b_r}) && !(&q_nx) ? q_nx + 1'b1 : q_nx;
`else
  assign q_fin = q_nx;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? BUSY : IDLE;
      BUSY:    state_nx = (exc_dbz || exc_ovf || cnt == '0) ? DONE : BUSY;
      DONE:    state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  // Exceptions spend one BUSY cycle so their result appears one edge after accept.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      p       <= '0;
      lo      <= '0;
      b_r     <= '0;
      qt      <= '0;
      cnt     <= '0;
      exc_dbz <= 1'b0;
      exc_ovf <= 1'b0;
      Q       <= '0;
      R       <= '0;
      ovf     <= 1'b0;
      dbz     <= 1'b0;
    end else if (state == IDLE && accept) begin
      p       <= A[2*WIDTH-1:WIDTH];
      lo      <= A[WIDTH-1:0];
      b_r     <= B;
      qt      <= '0;
      cnt     <= CW'(WIDTH - 1);
      exc_dbz <= B == '0;
      exc_ovf <= B != '0 && A[2*WIDTH-1:WIDTH] >= B;
    end else if (state == BUSY) begin
      if (exc_dbz || exc_ovf) begin
        Q   <= '1;
        R   <= exc_dbz ? lo : '0;
        ovf <= exc_ovf;
        dbz <= exc_dbz;
      end else begin
        p   <= p_nx;
        lo  <= {lo[WIDTH-2:0], 1'b0};
        qt  <= q_nx[WIDTH-2:0];
        cnt <= cnt - 1'b1;
        if (cnt == '0) begin
          Q   <= q_fin;
          R   <= p_nx;
          ovf <= 1'b0;
          dbz <= 1'b0;
        end
      end
    end
endmodule
